wb_master_initiator: RTL and testbench
======================================

// Module: wb_master_initiator
// PURPOSE
//   Wishbone classic single-transfer master: the initiator end of the bus our slave registers hang off.
//   Accepts one read/write command over a valid/ready port and runs one CYC/STB cycle to ACK.
//   Returns read data or an error over a valid/ready response port.
//   A watchdog aborts cycles that are never acknowledged. Sits between test/CPU logic and the WB fabric.
// PARAMETERS
//   ADDR_WIDTH      `ADDR_WIDTH  address bus width
//   DATA_WIDTH      `DATA_WIDTH  data bus width
//   TIMEOUT_CYCLES  16           max cycles STB is held without ACK before abort (>=2)
// PORTS
//   clk_i        in   1           clock, all logic on rising edge
//   rst_i        in   1           synchronous, active-high reset
//   cmd_valid_i  in   1           command present
//   cmd_ready_o  out  1           command accepted this cycle when valid&ready
//   cmd_we_i     in   1           1=write, 0=read
//   cmd_adr_i    in   ADDR_WIDTH  target address
//   cmd_dat_i    in   DATA_WIDTH  write data (ignored on read)
//   rsp_valid_o  out  1           response present
//   rsp_ready_i  in   1           response consumed when valid&ready
//   rsp_dat_o    out  DATA_WIDTH  read data; 0 on write or error
//   rsp_err_o    out  1           1 = timeout abort
//   cyc_o        out  1           WB cycle
//   stb_o        out  1           WB strobe
//   we_o         out  1           WB write enable
//   adr_o        out  ADDR_WIDTH  WB address
//   dat_o        out  DATA_WIDTH  WB write data
//   dat_i        in   DATA_WIDTH  WB read data
//   ack_i        in   1           WB acknowledge
// BEHAVIOUR
//   Reset: state IDLE; cyc_o,stb_o,we_o,adr_o,dat_o,rsp_valid_o,rsp_err_o,rsp_dat_o = 0; timeout counter = 0.
//   All outputs registered. cmd_ready_o = (state==IDLE), so it is 1 out of reset.
//   IDLE: on cmd_valid_i&cmd_ready_o, latch we/adr/dat, clear counter, go BUS.
//     Next cycle cyc_o=stb_o=1, adr_o/dat_o/we_o driven from the latch.
//   BUS: cyc_o,stb_o,adr_o,dat_o,we_o held stable.
//     - ack_i=1: go RESP. Capture dat_i into rsp_dat_o if read, else 0. rsp_err_o=0.
//     - else counter==TIMEOUT_CYCLES-1: go RESP. rsp_err_o=1, rsp_dat_o=0.
//     - else counter++.
//     - ack_i and timeout in the same cycle: ack wins (success).
//     - Counter width $clog2(TIMEOUT_CYCLES); never wraps. STB high for at most TIMEOUT_CYCLES cycles.
//   RESP: cyc_o=stb_o=we_o=0, adr_o=dat_o=0, rsp_valid_o=1.
//     - rsp_dat_o/rsp_err_o stable until rsp_ready_i=1, then IDLE next cycle.
//     - Guarantees STB low >=2 cycles between transfers, so a slave waiting for STB to drop can finish its phase.
//   Latency: cmd accepted at edge N -> STB high after N -> ack sampled at edge M -> rsp_valid_o high after M.
//   cmd_valid_i outside IDLE is ignored (not accepted, no side effect).
//   ack_i outside BUS is ignored.
//   rst_i in any state: returns to IDLE at that edge with all outputs at reset values.
//     Any in-flight transfer and pending response are dropped.
// TESTING
//   1 Reset mid-BUS: assert rst_i 1 cycle while stb_o=1 -> next cycle cyc_o=stb_o=rsp_valid_o=0, cmd_ready_o=1.
//   2 Write adr 0x10 dat 0x3C, slave acks 1st STB cycle -> we_o=1 adr_o=0x10 dat_o=0x3C for 1 cycle; rsp err=0 dat=0x00.
//   3 Read adr 0x5A vs team register slave (returns ~adr) -> rsp_dat_o=0xA5, rsp_err_o=0; rsp_valid_o 3 edges after accept.
//   4 ack_i tied 0, TIMEOUT_CYCLES=16 -> stb_o high exactly 16 cycles, then rsp_err_o=1, rsp_dat_o=0x00.
//   5 ack_i=1 in the 16th STB cycle (dat_i=0x77, read) -> success: rsp_err_o=0, rsp_dat_o=0x77.
//   6 Hold rsp_ready_i=0 for 5 cycles with cmd_valid_i=1 -> rsp held stable, cmd_ready_o=0, stb_o=0.
//     Next command accepted only in the cycle after the handshake.

Source files
------------

// File: rtl/wb_master_initiator_if.sv
// Bundle of the command/response handshake and Wishbone classic bus signals
// seen by the single-transfer master.
interface wb_master_initiator_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic                  rsp_err_o;
  logic                  cyc_o;
  logic                  stb_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic                  ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, dat_i, ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, cyc_o, stb_o, we_o, adr_o, dat_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, rsp_ready_i, dat_i, ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, cyc_o, stb_o, we_o, adr_o, dat_o
  );
endinterface

// File: rtl/wb_master_initiator.sv
// Wishbone classic single-transfer master: one command in, one CYC/STB cycle,
// one response out, with a watchdog that aborts unacknowledged cycles.
module wb_master_initiator #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  wb_master_initiator_if.master  bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic [CNT_W-1:0]      cnt_r, cnt_s;
  logic                  cmd_ready_r, cmd_ready_s;
  logic                  cyc_r, cyc_s;
  logic                  stb_r, stb_s;
  logic                  we_r, we_s;
  logic [ADDR_WIDTH-1:0] adr_r, adr_s;
  logic [DATA_WIDTH-1:0] dat_r, dat_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic                  rsp_err_r, rsp_err_s;
  logic [DATA_WIDTH-1:0] rsp_dat_r, rsp_dat_s;

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cmd_ready_s = cmd_ready_r;
    cyc_s       = cyc_r;
    stb_s       = stb_r;
    we_s        = we_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    rsp_valid_s = rsp_valid_r;
    rsp_err_s   = rsp_err_r;
    rsp_dat_s   = rsp_dat_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.cmd_valid_i && cmd_ready_r) begin
          state_s     = ST_BUS;
          cnt_s       = {CNT_W{1'b0}};
          cmd_ready_s = 1'b0;
          cyc_s       = 1'b1;
          stb_s       = 1'b1;
          we_s        = bus.cmd_we_i;
          adr_s       = bus.cmd_adr_i;
          dat_s       = bus.cmd_dat_i;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        // Ack is checked first so an ack in the last allowed cycle still succeeds.
        if (bus.ack_i || (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1))) begin
          state_s     = ST_RESP;
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          we_s        = 1'b0;
          adr_s       = {ADDR_WIDTH{1'b0}};
          dat_s       = {DATA_WIDTH{1'b0}};
          rsp_valid_s = 1'b1;
          rsp_err_s   = ~bus.ack_i;
          rsp_dat_s   = (bus.ack_i && !we_r) ? bus.dat_i : {DATA_WIDTH{1'b0}};
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_s     = ST_IDLE;
          cmd_ready_s = 1'b1;
          rsp_valid_s = 1'b0;
          rsp_err_s   = 1'b0;
          rsp_dat_s   = {DATA_WIDTH{1'b0}};
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        cnt_s       = {CNT_W{1'b0}};
        cmd_ready_s = 1'b1;
        cyc_s       = 1'b0;
        stb_s       = 1'b0;
        we_s        = 1'b0;
        adr_s       = {ADDR_WIDTH{1'b0}};
        dat_s       = {DATA_WIDTH{1'b0}};
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_dat_s   = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      cmd_ready_r <= 1'b1;
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= {ADDR_WIDTH{1'b0}};
      dat_r       <= {DATA_WIDTH{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_dat_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cmd_ready_r <= cmd_ready_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      we_r        <= we_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_err_r   <= rsp_err_s;
      rsp_dat_r   <= rsp_dat_s;
    end
  end

  assign bus.cmd_ready_o = cmd_ready_r;
  assign bus.cyc_o       = cyc_r;
  assign bus.stb_o       = stb_r;
  assign bus.we_o        = we_r;
  assign bus.adr_o       = adr_r;
  assign bus.dat_o       = dat_r;
  assign bus.rsp_valid_o = rsp_valid_r;
  assign bus.rsp_err_o   = rsp_err_r;
  assign bus.rsp_dat_o   = rsp_dat_r;
endmodule

// File: tb/tb_wb_master_initiator.sv
// Scoreboard bench for wb_master_initiator: expected responses are queued at
// command issue and compared when the response handshake appears.
module tb_wb_master_initiator;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] dat;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_master_initiator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  wb_master_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  rsp_t exp_q[$];

  // Either the register slave (one wait state, returns ~adr) or direct bench drive.
  logic          use_slave   = 1'b0;
  logic          tb_ack      = 1'b0;
  logic [DW-1:0] tb_dat      = 8'h00;
  logic          slave_wait_r = 1'b0;
  logic          slave_ack_r  = 1'b0;

  always_ff @(posedge clk) begin
    slave_wait_r <= use_slave & bus.cyc_o & bus.stb_o & ~slave_wait_r & ~slave_ack_r;
    slave_ack_r  <= use_slave & bus.cyc_o & bus.stb_o & slave_wait_r;
  end

  assign bus.ack_i = use_slave ? slave_ack_r : tb_ack;
  assign bus.dat_i = use_slave ? ~bus.adr_o : tb_dat;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                       output bit ok);
    logic rdy;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_valid_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      rdy = bus.cmd_ready_o;
      step();
      if (rdy) ok = 1'b1;
    end
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(output bit got, output int cyc);
    got = bus.rsp_valid_o;
    cyc = 0;
    while (!got && cyc < 60) begin
      step();
      cyc++;
      got = bus.rsp_valid_o;
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst = 1'b1;
    repeat (3) step();
    checks++; if ({bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o, bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o} !== '0) begin failures++; $display("FAIL reset_outputs got cyc=%0b stb=%0b rsp_valid=%0b adr=%h dat=%h rsp_dat=%h exp all 0", bus.cyc_o, bus.stb_o, bus.rsp_valid_o, bus.adr_o, bus.dat_o, bus.rsp_dat_o); end
    checks++; if (bus.cmd_ready_o !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready got=%0b exp=1", bus.cmd_ready_o); end
    rst = 1'b0;
    step();
    tb_ack = 1'b0;
    issue(1'b1, 8'h44, 8'h99, ok);
    checks++; if (!ok || bus.stb_o !== 1'b1) begin failures++; $display("FAIL midbus_start got ok=%0b stb=%0b exp ok=1 stb=1", ok, bus.stb_o); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if ({bus.cyc_o, bus.stb_o, bus.rsp_valid_o, bus.cmd_ready_o} !== 4'b0001) begin failures++; $display("FAIL midbus_reset got cyc=%0b stb=%0b rsp_valid=%0b ready=%0b exp 0 0 0 1", bus.cyc_o, bus.stb_o, bus.rsp_valid_o, bus.cmd_ready_o); end
    repeat (3) step();
    checks++; if ({bus.stb_o, bus.rsp_valid_o} !== 2'b00) begin failures++; $display("FAIL midbus_dropped got stb=%0b rsp_valid=%0b exp 0 0", bus.stb_o, bus.rsp_valid_o); end
  endtask

  task automatic test_write();
    bit   ok, got;
    int   cyc;
    rsp_t e;
    tb_dat = 8'hEE;
    issue(1'b1, 8'h10, 8'h3C, ok);
    exp_q.push_back('{err: 1'b0, dat: 8'h00});
    checks++; if (!ok || {bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o} !== {3'b111, 8'h10, 8'h3C}) begin failures++; $display("FAIL write_bus got ok=%0b cyc=%0b stb=%0b we=%0b adr=%h dat=%h exp 1 1 1 1 10 3c", ok, bus.cyc_o, bus.stb_o, bus.we_o, bus.adr_o, bus.dat_o); end
    tb_ack = 1'b1;
    step();
    tb_ack = 1'b0;
    checks++; if (bus.stb_o !== 1'b0) begin failures++; $display("FAIL write_stb_len got stb=%0b exp=0", bus.stb_o); end
    wait_rsp(got, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || bus.rsp_err_o !== e.err || bus.rsp_dat_o !== e.dat) begin failures++; $display("FAIL write_rsp got valid=%0b err=%0b dat=%h exp valid=1 err=%0b dat=%h", got, bus.rsp_err_o, bus.rsp_dat_o, e.err, e.dat); end
    step();
    checks++; if ({bus.rsp_valid_o, bus.cmd_ready_o} !== 2'b01) begin failures++; $display("FAIL write_back_idle got rsp_valid=%0b ready=%0b exp 0 1", bus.rsp_valid_o, bus.cmd_ready_o); end
  endtask

  task automatic test_read_slave();
    bit            ok, got;
    int            cyc;
    rsp_t          e;
    logic [AW-1:0] adr;
    adr = 8'h5A;
    use_slave = 1'b1;
    issue(1'b0, adr, 8'h00, ok);
    exp_q.push_back('{err: 1'b0, dat: ~adr});
    wait_rsp(got, cyc);
    checks++; if (!ok || !got || cyc != 3) begin failures++; $display("FAIL read_latency got ok=%0b valid=%0b edges=%0d exp edges=3", ok, got, cyc); end
    e = exp_q.pop_front();
    checks++; if (bus.rsp_err_o !== e.err || bus.rsp_dat_o !== e.dat) begin failures++; $display("FAIL read_rsp got err=%0b dat=%h exp err=%0b dat=%h", bus.rsp_err_o, bus.rsp_dat_o, e.err, e.dat); end
    step();
    use_slave = 1'b0;
  endtask

  task automatic test_timeout();
    bit   ok, got;
    int   cyc, stb_cnt;
    rsp_t e;
    tb_ack = 1'b0;
    tb_dat = 8'h55;
    issue(1'b0, 8'h21, 8'h00, ok);
    exp_q.push_back('{err: 1'b1, dat: 8'h00});
    stb_cnt = 0;
    while (bus.stb_o && stb_cnt < 40) begin
      stb_cnt++;
      step();
    end
    checks++; if (!ok || stb_cnt != TO) begin failures++; $display("FAIL timeout_stb_cycles got ok=%0b cycles=%0d exp=%0d", ok, stb_cnt, TO); end
    wait_rsp(got, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || bus.rsp_err_o !== e.err || bus.rsp_dat_o !== e.dat) begin failures++; $display("FAIL timeout_rsp got valid=%0b err=%0b dat=%h exp valid=1 err=%0b dat=%h", got, bus.rsp_err_o, bus.rsp_dat_o, e.err, e.dat); end
    step();
  endtask

  task automatic test_ack_last_cycle();
    bit   ok, got;
    int   cyc;
    rsp_t e;
    tb_dat = 8'h77;
    issue(1'b0, 8'h42, 8'h00, ok);
    exp_q.push_back('{err: 1'b0, dat: 8'h77});
    repeat (TO - 1) step();
    checks++; if (!ok || bus.stb_o !== 1'b1) begin failures++; $display("FAIL last_cycle_stb got ok=%0b stb=%0b exp stb=1", ok, bus.stb_o); end
    tb_ack = 1'b1;
    step();
    tb_ack = 1'b0;
    wait_rsp(got, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || bus.rsp_err_o !== e.err || bus.rsp_dat_o !== e.dat) begin failures++; $display("FAIL last_cycle_rsp got valid=%0b err=%0b dat=%h exp valid=1 err=%0b dat=%h", got, bus.rsp_err_o, bus.rsp_dat_o, e.err, e.dat); end
    step();
  endtask

  task automatic test_back_to_back();
    bit   ok, got;
    int   cyc;
    rsp_t e;
    tb_dat = 8'hC3;
    issue(1'b1, 8'h60, 8'h11, ok);
    exp_q.push_back('{err: 1'b0, dat: 8'h00});
    bus.rsp_ready_i = 1'b0;
    tb_ack = 1'b1;
    step();
    tb_ack = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 8'h61;
    bus.cmd_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (!ok || {bus.rsp_valid_o, bus.cmd_ready_o, bus.stb_o} !== 3'b100 || bus.rsp_err_o !== exp_q[0].err || bus.rsp_dat_o !== exp_q[0].dat) begin failures++; $display("FAIL hold_rsp cycle=%0d got valid=%0b ready=%0b stb=%0b err=%0b dat=%h exp 1 0 0 err=%0b dat=%h", i, bus.rsp_valid_o, bus.cmd_ready_o, bus.stb_o, bus.rsp_err_o, bus.rsp_dat_o, exp_q[0].err, exp_q[0].dat); end
      step();
    end
    e = exp_q.pop_front();
    checks++; if (bus.rsp_valid_o !== 1'b1 || bus.rsp_err_o !== e.err || bus.rsp_dat_o !== e.dat) begin failures++; $display("FAIL hold_final_rsp got valid=%0b err=%0b dat=%h exp 1 err=%0b dat=%h", bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_dat_o, e.err, e.dat); end
    bus.rsp_ready_i = 1'b1;
    step();
    checks++; if ({bus.rsp_valid_o, bus.stb_o, bus.cmd_ready_o} !== 3'b001) begin failures++; $display("FAIL after_handshake got valid=%0b stb=%0b ready=%0b exp 0 0 1", bus.rsp_valid_o, bus.stb_o, bus.cmd_ready_o); end
    step();
    bus.cmd_valid_i = 1'b0;
    exp_q.push_back('{err: 1'b0, dat: 8'h99});
    checks++; if ({bus.stb_o, bus.we_o, bus.adr_o} !== {2'b10, 8'h61}) begin failures++; $display("FAIL second_accept got stb=%0b we=%0b adr=%h exp 1 0 61", bus.stb_o, bus.we_o, bus.adr_o); end
    tb_dat = 8'h99;
    tb_ack = 1'b1;
    step();
    tb_ack = 1'b0;
    wait_rsp(got, cyc);
    e = exp_q.pop_front();
    checks++; if (!got || bus.rsp_err_o !== e.err || bus.rsp_dat_o !== e.dat) begin failures++; $display("FAIL second_rsp got valid=%0b err=%0b dat=%h exp valid=1 err=%0b dat=%h", got, bus.rsp_err_o, bus.rsp_dat_o, e.err, e.dat); end
    step();
  endtask

  initial begin
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 8'h00;
    bus.cmd_dat_i   = 8'h00;
    bus.rsp_ready_i = 1'b1;
    test_reset();
    test_write();
    test_read_slave();
    test_timeout();
    test_ack_last_cycle();
    test_back_to_back();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_empty got=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=stuck exp=finish");
    $fatal(1, "simulation time limit");
  end
endmodule
